pl_trace_buf: RTL and testbench
===============================

Name: pl_trace_buf

Overview:
- Synthesizable retire-trace and performance-counter block for the pipelined RISC-V core (rv_pl).
- Records each retiring writeback event (PC, rd, we_rf, result) into a parametrised circular buffer.
- Counts cycles, stalls, flushes and retirements, and supports wrap, stop-when-full and PC-trigger capture modes.
- Sits beside the core, fed by WB-stage and hazard-unit signals; read out through a valid/ready pop port.

Parameters:
DEPTH, 16, number of trace entries; power of two, at least 2
PC_W, 32, PC width
DATA_W, 32, writeback result width
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
w_valid  in  1  an instruction retires in WB this cycle
w_pc  in  PC_W  PC of the retiring instruction
w_we_rf  in  1  retiring instruction writes the register file
w_rd  in  5  destination register
w_result  in  DATA_W  writeback result
pc_en  in  1  hazard PC enable; 0 means stall
id_ex_clr  in  1  ID/EX flush
arm  in  1  single-cycle pulse: clear and start capture
mode  in  2  0 wrap, 1 stop-full, 2 trigger, 3 treated as 0
trig_pc  in  PC_W  trigger PC (mode 2)
post_cnt  in  8  entries recorded after the trigger entry (mode 2)
rd_valid  out  1  head entry available
rd_ready  in  1  consumer accepts head entry
rd_pc  out  PC_W  head entry PC
rd_rd  out  5  head entry rd
rd_we  out  1  head entry we_rf
rd_data  out  DATA_W  head entry result
count  out  $clog2(DEPTH)+1  entries held
overflow  out  1  sticky: an entry was overwritten
triggered  out  1  sticky: trigger matched
busy  out  1  state is CAPTURE or POST
done  out  1  state is DONE
cyc_cnt, stall_cnt, flush_cnt, retire_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset: state IDLE; pointers, count, flags and counters all 0; rd_valid=0; rd_* outputs 0.
- States:
  - IDLE -arm-> CAPTURE.
  - CAPTURE -(mode1 and count reaches DEPTH after a push)-> DONE.
  - CAPTURE -(mode2 and trigger recorded)-> POST, or -> DONE if post_cnt=0.
  - POST -(remaining reaches 0)-> DONE.
  - DONE -arm-> CAPTURE.
- arm in any state, including mid-capture: next cycle pointers, count, overflow, triggered and all counters are 0, state is CAPTURE. A w_valid in the arm cycle is not recorded.
- Push: w_valid=1 in CAPTURE or POST writes {w_pc, w_rd, w_we_rf, w_result} at the write pointer; the entry is visible the next cycle. w_valid is ignored in IDLE and DONE.
- Full push without pop (modes 0 and 2): oldest entry is overwritten, read pointer advances, count stays DEPTH, overflow set.
- Full push without pop (mode 1): cannot occur, because the block enters DONE on the push that fills it.
- Pop: rd_valid=(count!=0). rd_* show the head entry, first-word fall-through. rd_valid&rd_ready advances the read pointer. Pops are legal in every state.
- Push and pop in the same cycle: both take effect, count unchanged, no overflow even when full.
- Pointers wrap modulo DEPTH.
- Trigger (mode 2, CAPTURE only): a recorded entry with w_pc==trig_pc sets triggered and loads remaining=post_cnt. In POST each recorded entry decrements remaining; the entry taking it to 0 is recorded, then state becomes DONE. Further matches in POST are ignored.
- Counters increment only when busy=1, in the same cycle as their event, and saturate at all-ones:
  - cyc_cnt: every cycle.
  - stall_cnt: when pc_en=0.
  - flush_cnt: when id_ex_clr=1.
  - retire_cnt: when w_valid=1.
- In DONE all counters are frozen.
- Counter and status outputs are registered.

Test Plan:
- Reset mid-capture after 5 pushes -> next cycle count=0, rd_valid=0, all counters 0, busy=0.
- DEPTH=4, mode 0, arm, 6 retires at PC 0x00,0x04..0x14 -> count=4, overflow=1; pops return 0x08,0x0C,0x10,0x14, then rd_valid=0.
- DEPTH=4, mode 1, 5 retires -> done=1 after the 4th; 5th ignored; retire_cnt=4; pops return first 4 PCs.
- Mode 2, trig_pc=0x20, post_cnt=2, retires 0x00..0x30 step 4 -> triggered=1, DONE after PC 0x28; last buffered entry 0x28.
- 10 cycles capture with pc_en=0 for 3 cycles and id_ex_clr=1 for 1 cycle -> cyc_cnt=10, stall_cnt=3, flush_cnt=1.
- DEPTH=4 full in mode 0, simultaneous push and pop -> popped entry is the oldest, count stays 4, overflow stays 0.

Source files
------------

// File: rtl/pl_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : pl_trace_buf
// Brief    : Retire-trace circular buffer with performance counters for the
//            rv_pl pipelined core. Captures WB retire events in wrap,
//            stop-when-full or PC-trigger mode; read out via valid/ready pop.
// Revision : 1.0 - initial release
// ============================================================================
module pl_trace_buf #(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     w_valid,
    input  logic [PC_W-1:0]          w_pc,
    input  logic                     w_we_rf,
    input  logic [4:0]               w_rd,
    input  logic [DATA_W-1:0]        w_result,
    input  logic                     pc_en,
    input  logic                     id_ex_clr,
    input  logic                     arm,
    input  logic [1:0]               mode,
    input  logic [PC_W-1:0]          trig_pc,
    input  logic [7:0]               post_cnt,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [PC_W-1:0]          rd_pc,
    output logic [4:0]               rd_rd,
    output logic                     rd_we,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     triggered,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         cyc_cnt,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt,
    output logic [CNT_W-1:0]         retire_cnt
);

    localparam int               c_AW   = $clog2(DEPTH);
    localparam int               c_EW   = PC_W + 5 + 1 + DATA_W;
    localparam logic [c_AW:0]    c_FULL = (c_AW+1)'(DEPTH);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CAPTURE = 2'd1;
    localparam logic [1:0] c_POST    = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    localparam logic [1:0] c_MODE_STOP = 2'd1;
    localparam logic [1:0] c_MODE_TRIG = 2'd2;

    logic [c_EW-1:0]   r_mem [DEPTH];
    logic [1:0]        r_state;
    logic [c_AW-1:0]   r_wptr;
    logic [c_AW-1:0]   r_rptr;
    logic [c_AW:0]     r_count;
    logic [7:0]        r_remaining;
    logic              r_overflow;
    logic              r_triggered;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_cyc;
    logic [CNT_W-1:0]  r_stall;
    logic [CNT_W-1:0]  r_flush;
    logic [CNT_W-1:0]  r_retire;

    logic [1:0]        w_state_nxt;
    logic [7:0]        w_rem_nxt;
    logic              w_trig_set;
    logic [c_AW:0]     w_count_nxt;
    logic [1:0]        w_mode_eff;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic [c_EW-1:0]   w_head;

    // Mode 3 is an alias of wrap mode
    assign w_mode_eff = (mode == 2'd3) ? 2'd0 : mode;
    assign w_full     = (r_count == c_FULL);
    assign w_push     = w_valid & r_busy & ~arm;
    assign w_pop      = (r_count != '0) & rd_ready & ~arm;

    // Occupancy after this cycle; a push into a full buffer overwrites
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = w_full ? r_count : r_count + (c_AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (c_AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Next-state logic for the capture controller and post-trigger countdown
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_remaining;
        w_trig_set  = 1'b0;
        if (arm) begin
            w_state_nxt = c_CAPTURE;
            w_rem_nxt   = 8'd0;
        end else begin
            case (r_state)
                c_CAPTURE: begin
                    if (w_push) begin
                        if (w_mode_eff == c_MODE_STOP && w_count_nxt == c_FULL) begin
                            w_state_nxt = c_DONE;
                        end else if (w_mode_eff == c_MODE_TRIG && w_pc == trig_pc) begin
                            w_trig_set = 1'b1;
                            if (post_cnt == 8'd0) begin
                                w_state_nxt = c_DONE;
                            end else begin
                                w_state_nxt = c_POST;
                                w_rem_nxt   = post_cnt;
                            end
                        end
                    end
                end
                c_POST: begin
                    if (w_push) begin
                        w_rem_nxt = r_remaining - 8'd1;
                        if (r_remaining == 8'd1) begin
                            w_state_nxt = c_DONE;
                        end
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Trace storage; contents are only observable while count is non-zero
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_pc, w_rd, w_we_rf, w_result};
        end
    end

    // State, pointers, flags and saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_remaining <= 8'd0;
            r_overflow  <= 1'b0;
            r_triggered <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cyc       <= '0;
            r_stall     <= '0;
            r_flush     <= '0;
            r_retire    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_rem_nxt;
            r_busy      <= (w_state_nxt == c_CAPTURE) || (w_state_nxt == c_POST);
            r_done      <= (w_state_nxt == c_DONE);
            if (arm) begin
                r_wptr      <= '0;
                r_rptr      <= '0;
                r_count     <= '0;
                r_overflow  <= 1'b0;
                r_triggered <= 1'b0;
                r_cyc       <= '0;
                r_stall     <= '0;
                r_flush     <= '0;
                r_retire    <= '0;
            end else begin
                r_count <= w_count_nxt;
                if (w_push) begin
                    r_wptr <= r_wptr + c_AW'(1);
                end
                if (w_pop || (w_push && w_full)) begin
                    r_rptr <= r_rptr + c_AW'(1);
                end
                if (w_push && w_full && !w_pop) begin
                    r_overflow <= 1'b1;
                end
                if (w_trig_set) begin
                    r_triggered <= 1'b1;
                end
                if (r_busy) begin
                    if (~&r_cyc) r_cyc <= r_cyc + CNT_W'(1);
                    if (!pc_en && ~&r_stall) r_stall <= r_stall + CNT_W'(1);
                    if (id_ex_clr && ~&r_flush) r_flush <= r_flush + CNT_W'(1);
                    if (w_valid && ~&r_retire) r_retire <= r_retire + CNT_W'(1);
                end
            end
        end
    end

    assign w_head     = r_mem[r_rptr];
    assign rd_valid   = (r_count != '0);
    assign rd_pc      = rd_valid ? w_head[c_EW-1 -: PC_W]     : '0;
    assign rd_rd      = rd_valid ? w_head[DATA_W+5 -: 5]      : 5'd0;
    assign rd_we      = rd_valid ? w_head[DATA_W]             : 1'b0;
    assign rd_data    = rd_valid ? w_head[DATA_W-1:0]         : '0;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign triggered  = r_triggered;
    assign busy       = r_busy;
    assign done       = r_done;
    assign cyc_cnt    = r_cyc;
    assign stall_cnt  = r_stall;
    assign flush_cnt  = r_flush;
    assign retire_cnt = r_retire;

endmodule
`default_nettype wire

// File: tb/tb_pl_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pl_trace_buf
// Brief    : Self-checking bench for pl_trace_buf: vector table, directed
//            corner sequences and randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pl_trace_buf;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int DW    = 32;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              w_valid, w_we_rf, pc_en, id_ex_clr, arm, rd_ready;
    logic [PC_W-1:0]   w_pc, trig_pc;
    logic [4:0]        w_rd;
    logic [DW-1:0]     w_result;
    logic [1:0]        mode;
    logic [7:0]        post_cnt;
    logic              rd_valid, rd_we, overflow, triggered, busy, done;
    logic [PC_W-1:0]   rd_pc;
    logic [4:0]        rd_rd;
    logic [DW-1:0]     rd_data;
    logic [2:0]        count;
    logic [CNT_W-1:0]  cyc_cnt, stall_cnt, flush_cnt, retire_cnt;

    int n_vec = 0;
    int n_err = 0;

    pl_trace_buf #(.DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .w_valid(w_valid), .w_pc(w_pc), .w_we_rf(w_we_rf), .w_rd(w_rd), .w_result(w_result),
        .pc_en(pc_en), .id_ex_clr(id_ex_clr), .arm(arm), .mode(mode),
        .trig_pc(trig_pc), .post_cnt(post_cnt),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_rd(rd_rd),
        .rd_we(rd_we), .rd_data(rd_data), .count(count), .overflow(overflow),
        .triggered(triggered), .busy(busy), .done(done),
        .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        logic            we;
        logic [DW-1:0]   data;
    } ent_t;

    ent_t mq[$];
    int   m_st;            // 0 idle, 1 capture, 2 post, 3 done
    bit   m_ovf, m_trg;
    int   m_rem;
    int   m_cyc, m_stl, m_fls, m_ret;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic void model_clear(input int st);
        mq.delete();
        m_st = st; m_ovf = 0; m_trg = 0; m_rem = 0;
        m_cyc = 0; m_stl = 0; m_fls = 0; m_ret = 0;
    endfunction

    function automatic void model_step();
        ent_t e;
        bit   mbusy, push, pop;
        int   m;
        if (!rst_n) begin model_clear(0); return; end
        if (arm)    begin model_clear(1); return; end
        mbusy = (m_st == 1) || (m_st == 2);
        push  = w_valid && mbusy;
        pop   = (mq.size() != 0) && rd_ready;
        if (mbusy) begin
            m_cyc = sat(m_cyc + 1);
            if (!pc_en)    m_stl = sat(m_stl + 1);
            if (id_ex_clr) m_fls = sat(m_fls + 1);
            if (w_valid)   m_ret = sat(m_ret + 1);
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() == DEPTH) begin
                void'(mq.pop_front());
                m_ovf = 1;
            end
            e.pc = w_pc; e.rd = w_rd; e.we = w_we_rf; e.data = w_result;
            mq.push_back(e);
            m = (mode == 2'd3) ? 0 : int'(mode);
            if (m_st == 1) begin
                if (m == 1 && mq.size() == DEPTH) m_st = 3;
                else if (m == 2 && w_pc == trig_pc) begin
                    m_trg = 1;
                    if (post_cnt == 0) m_st = 3;
                    else begin m_st = 2; m_rem = int'(post_cnt); end
                end
            end else begin
                m_rem = m_rem - 1;
                if (m_rem == 0) m_st = 3;
            end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err < 60) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all();
        ent_t h;
        h = '0;
        if (mq.size() != 0) h = mq[0];
        check("r_count",     64'(count),      64'(mq.size()));
        check("r_rd_valid",  64'(rd_valid),   64'(mq.size() != 0));
        check("r_rd_pc",     64'(rd_pc),      64'(h.pc));
        check("r_rd_rd",     64'(rd_rd),      64'(h.rd));
        check("r_rd_we",     64'(rd_we),      64'(h.we));
        check("r_rd_data",   64'(rd_data),    64'(h.data));
        check("r_overflow",  64'(overflow),   64'(m_ovf));
        check("r_triggered", 64'(triggered),  64'(m_trg));
        check("r_busy",      64'(busy),       64'(m_st == 1 || m_st == 2));
        check("r_done",      64'(done),       64'(m_st == 3));
        check("r_cyc",       64'(cyc_cnt),    64'(m_cyc));
        check("r_stall",     64'(stall_cnt),  64'(m_stl));
        check("r_flush",     64'(flush_cnt),  64'(m_fls));
        check("r_retire",    64'(retire_cnt), 64'(m_ret));
    endtask

    task automatic push_pc(input logic [PC_W-1:0] pc);
        w_valid = 1'b1; w_pc = pc; w_rd = pc[6:2]; w_result = ~pc; w_we_rf = pc[2];
        tick();
        w_valid = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit              arm;
        bit [1:0]        mode;
        bit              wv;
        logic [PC_W-1:0] pc;
        bit              rdy;
        int              exp_count;
        logic [PC_W-1:0] exp_pc;
        bit              exp_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit a, input bit [1:0] md, input bit wv,
                                input logic [PC_W-1:0] pc, input bit rdy,
                                input int ec, input logic [PC_W-1:0] epc, input bit eo);
        vec_t v;
        v.arm = a; v.mode = md; v.wv = wv; v.pc = pc; v.rdy = rdy;
        v.exp_count = ec; v.exp_pc = epc; v.exp_ovf = eo;
        return v;
    endfunction

    initial begin
        logic [DW-1:0] edata;

        rst_n = 1'b0; w_valid = 0; w_pc = '0; w_we_rf = 0; w_rd = '0; w_result = '0;
        pc_en = 1; id_ex_clr = 0; arm = 0; mode = 2'd0; trig_pc = '0; post_cnt = 8'd0;
        rd_ready = 0;

        // mode 0 wrap with 6 retires, then drain
        tbl.push_back(mk(1, 0, 0, 32'h00, 0, 0, 32'h00, 0));
        tbl.push_back(mk(0, 0, 1, 32'h00, 0, 1, 32'h00, 0));
        tbl.push_back(mk(0, 0, 1, 32'h04, 0, 2, 32'h00, 0));
        tbl.push_back(mk(0, 0, 1, 32'h08, 0, 3, 32'h00, 0));
        tbl.push_back(mk(0, 0, 1, 32'h0C, 0, 4, 32'h00, 0));
        tbl.push_back(mk(0, 0, 1, 32'h10, 0, 4, 32'h04, 1));
        tbl.push_back(mk(0, 0, 1, 32'h14, 0, 4, 32'h08, 1));
        tbl.push_back(mk(0, 0, 0, 32'h00, 0, 4, 32'h08, 1));
        tbl.push_back(mk(0, 0, 0, 32'h00, 1, 3, 32'h0C, 1));
        tbl.push_back(mk(0, 0, 0, 32'h00, 1, 2, 32'h10, 1));
        tbl.push_back(mk(0, 0, 0, 32'h00, 1, 1, 32'h14, 1));
        tbl.push_back(mk(0, 0, 0, 32'h00, 1, 0, 32'h00, 1));
        tbl.push_back(mk(0, 0, 0, 32'h00, 1, 0, 32'h00, 1));
        // full buffer, simultaneous push and pop
        tbl.push_back(mk(1, 0, 0, 32'h00,  0, 0, 32'h000, 0));
        tbl.push_back(mk(0, 0, 1, 32'h100, 0, 1, 32'h100, 0));
        tbl.push_back(mk(0, 0, 1, 32'h104, 0, 2, 32'h100, 0));
        tbl.push_back(mk(0, 0, 1, 32'h108, 0, 3, 32'h100, 0));
        tbl.push_back(mk(0, 0, 1, 32'h10C, 0, 4, 32'h100, 0));
        tbl.push_back(mk(0, 0, 1, 32'h110, 1, 4, 32'h104, 0));
        tbl.push_back(mk(0, 0, 1, 32'h114, 1, 4, 32'h108, 0));
        // mode 3 behaves as wrap
        tbl.push_back(mk(1, 3, 0, 32'h000, 0, 0, 32'h000, 0));
        tbl.push_back(mk(0, 3, 1, 32'h200, 0, 1, 32'h200, 0));
        tbl.push_back(mk(0, 3, 1, 32'h204, 0, 2, 32'h200, 0));
        tbl.push_back(mk(0, 3, 1, 32'h208, 0, 3, 32'h200, 0));
        tbl.push_back(mk(0, 3, 1, 32'h20C, 0, 4, 32'h200, 0));
        tbl.push_back(mk(0, 3, 1, 32'h210, 0, 4, 32'h204, 1));

        // reset state
        tick(); tick();
        check("rst_count", 64'(count), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_pc", 64'(rd_pc), 64'd0);
        check("rst_busy_done", 64'({busy, done}), 64'd0);
        check("rst_cyc", 64'(cyc_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        // table
        for (int i = 0; i < tbl.size(); i++) begin
            arm = tbl[i].arm; mode = tbl[i].mode; w_valid = tbl[i].wv; rd_ready = tbl[i].rdy;
            w_pc = tbl[i].pc; w_rd = tbl[i].pc[6:2]; w_result = ~tbl[i].pc; w_we_rf = 1'b1;
            tick();
            edata = (tbl[i].exp_count != 0) ? ~tbl[i].exp_pc : '0;
            check($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].exp_count));
            check($sformatf("tbl%0d_valid", i), 64'(rd_valid), 64'(tbl[i].exp_count != 0));
            check($sformatf("tbl%0d_pc", i), 64'(rd_pc), 64'(tbl[i].exp_pc));
            check($sformatf("tbl%0d_data", i), 64'(rd_data), 64'(edata));
            check($sformatf("tbl%0d_ovf", i), 64'(overflow), 64'(tbl[i].exp_ovf));
        end
        arm = 0; w_valid = 0; rd_ready = 0;

        // mode 1: stop when full
        mode = 2'd1; arm = 1; tick(); arm = 0;
        for (int k = 0; k < 5; k++) begin
            push_pc(32'(k * 4));
            if (k == 2) check("m1_busy_k2", 64'({busy, done}), 64'b10);
            if (k == 3) check("m1_done_k3", 64'(done), 64'd1);
        end
        check("m1_count", 64'(count), 64'd4);
        check("m1_retire", 64'(retire_cnt), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("m1_pop%0d", k), 64'(rd_pc), 64'(k * 4));
            rd_ready = 1; tick(); rd_ready = 0;
        end
        check("m1_empty", 64'(rd_valid), 64'd0);

        // mode 2: trigger with post count
        mode = 2'd2; trig_pc = 32'h20; post_cnt = 8'd2; arm = 1; tick(); arm = 0;
        for (int k = 0; k <= 12; k++) begin
            push_pc(32'(k * 4));
            if (k == 8)  check("m2_trig_at20", 64'({triggered, busy, done}), 64'b110);
            if (k == 9)  check("m2_post_at24", 64'({busy, done}), 64'b10);
            if (k == 10) check("m2_done_at28", 64'({triggered, done}), 64'b11);
        end
        check("m2_count", 64'(count), 64'd4);
        check("m2_head", 64'(rd_pc), 64'h1C);
        rd_ready = 1; tick(); tick(); tick(); rd_ready = 0;
        check("m2_last", 64'(rd_pc), 64'h28);
        check("m2_count1", 64'(count), 64'd1);

        // post_cnt = 0 ends capture on the trigger entry itself
        post_cnt = 8'd0; trig_pc = 32'h08; arm = 1; tick(); arm = 0;
        push_pc(32'h04); push_pc(32'h08); push_pc(32'h0C);
        check("m2z_done", 64'({triggered, done}), 64'b11);
        check("m2z_count", 64'(count), 64'd2);

        // counters over 10 capture cycles
        mode = 2'd0; arm = 1; pc_en = 0; tick(); arm = 0;
        for (int k = 0; k < 10; k++) begin
            pc_en = !(k >= 2 && k <= 4);
            id_ex_clr = (k == 6);
            tick();
        end
        pc_en = 1; id_ex_clr = 0;
        check("cnt_cyc", 64'(cyc_cnt), 64'd10);
        check("cnt_stall", 64'(stall_cnt), 64'd3);
        check("cnt_flush", 64'(flush_cnt), 64'd1);
        check("cnt_retire", 64'(retire_cnt), 64'd0);

        // arm mid-capture with a retire in the arm cycle
        push_pc(32'h40); push_pc(32'h44); push_pc(32'h48);
        arm = 1; w_valid = 1; w_pc = 32'h99; tick(); arm = 0; w_valid = 0;
        check("rearm_count", 64'(count), 64'd0);
        check("rearm_cnts", 64'({cyc_cnt, retire_cnt}), 64'd0);
        check("rearm_busy", 64'(busy), 64'd1);

        // saturation
        for (int k = 0; k < 260; k++) tick();
        check("sat_cyc", 64'(cyc_cnt), 64'(CMAX));

        // counters frozen in DONE
        mode = 2'd1; arm = 1; tick(); arm = 0;
        for (int k = 0; k < 4; k++) push_pc(32'(k * 4));
        for (int k = 0; k < 5; k++) tick();
        check("frz_done", 64'(done), 64'd1);
        check("frz_cyc", 64'(cyc_cnt), 64'd4);

        // asynchronous reset mid-capture
        mode = 2'd0; arm = 1; tick(); arm = 0;
        for (int k = 0; k < 5; k++) push_pc(32'(k * 4));
        rst_n = 0; tick();
        check("rstm_count", 64'(count), 64'd0);
        check("rstm_valid", 64'(rd_valid), 64'd0);
        check("rstm_cnts", 64'({cyc_cnt, stall_cnt, flush_cnt, retire_cnt}), 64'd0);
        check("rstm_busy", 64'(busy), 64'd0);
        rst_n = 1;
        tick();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            arm = ($urandom_range(0, 99) < 2);
            if (arm) begin
                mode     = 2'($urandom_range(0, 3));
                trig_pc  = 32'($urandom_range(0, 15)) << 2;
                post_cnt = 8'($urandom_range(0, 5));
            end
            if ($urandom_range(0, 499) == 0) rst_n = 0;
            w_valid   = ($urandom_range(0, 9) < 6);
            w_pc      = 32'($urandom_range(0, 15)) << 2;
            w_rd      = 5'($urandom);
            w_we_rf   = 1'($urandom);
            w_result  = $urandom;
            pc_en     = ($urandom_range(0, 3) != 0);
            id_ex_clr = ($urandom_range(0, 7) == 0);
            rd_ready  = ($urandom_range(0, 9) < 3);
            tick();
            rst_n = 1;
            check_all();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
